// File: rtl/x3q16_arb_pkg.sv
// Shared definitions for the x3q16 two-master memory arbiter:
// FSM states, request-type encodings and requester port indices.
package x3q16_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  localparam logic REQ_READ  = 1'b0;
  localparam logic REQ_WRITE = 1'b1;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage

// File: rtl/x3q16_req_slot.sv
// Per-port request capture slot for the x3q16 memory arbiter.
// Holds one outstanding request; a pulse while the slot is occupied is
// dropped and flagged sticky in o_overrun. Capture beats a same-cycle clear.
module x3q16_req_slot #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic              i_type,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_clr,
  output logic              o_pending,
  output logic              o_overrun,
  output logic              o_type,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_data
);

  logic              r_pending;
  logic              r_overrun;
  logic              r_type;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;

  logic w_accept;

  // A freed slot (either empty or being cleared this cycle) accepts a pulse.
  assign w_accept = i_req && (!r_pending || i_clr);

  // Capture, pending and sticky-overrun bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
      r_type    <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
    end else begin
      if (w_accept) begin
        r_pending <= 1'b1;
        r_type    <= i_type;
        r_addr    <= i_addr;
        r_data    <= i_data;
      end else if (i_clr) begin
        r_pending <= 1'b0;
      end
      if (i_req && !w_accept) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign o_pending = r_pending;
  assign o_overrun = r_overrun;
  assign o_type    = r_type;
  assign o_addr    = r_addr;
  assign o_data    = r_data;

endmodule

// File: rtl/x3q16_mem_arbiter.sv
// Two-requester arbiter sharing the x3q16 memory port between the CPU (m0)
// and a secondary bus master (m1). One transaction in flight at a time,
// alternating grant when both ports are pending.
// Optional feature macro: ARB_TIMEOUT_EN (adds a WAIT-state timeout and the
// sticky timeout_err output).
module x3q16_mem_arbiter
  import x3q16_arb_pkg::*;
#(
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_request,
  input  logic              m0_request_type,
  input  logic [ADDR_W-1:0] m0_request_address,
  input  logic [DATA_W-1:0] m0_data_out,
  output logic [DATA_W-1:0] m0_memory_in,
  output logic              m0_memory_ready,
  output logic              m0_write_complete,
  input  logic              m1_request,
  input  logic              m1_request_type,
  input  logic [ADDR_W-1:0] m1_request_address,
  input  logic [DATA_W-1:0] m1_data_out,
  output logic [DATA_W-1:0] m1_memory_in,
  output logic              m1_memory_ready,
  output logic              m1_write_complete,
  output logic              request,
  output logic              request_type,
  output logic [ADDR_W-1:0] request_address,
  output logic [DATA_W-1:0] data_out,
  input  logic [DATA_W-1:0] memory_in,
  input  logic              memory_ready,
  input  logic              write_complete,
  output logic              owner,
  output logic              busy,
`ifdef ARB_TIMEOUT_EN
  output logic              timeout_err,
`endif
  output logic [1:0]        overrun
);

  arb_state_t r_state;

  logic                   r_request;
  logic                   r_request_type;
  logic [ADDR_W-1:0]      r_request_address;
  logic [DATA_W-1:0]      r_data_out;
  logic                   r_owner;
  logic                   r_last_grant;
  logic                   r_busy;
  logic [1:0][DATA_W-1:0] r_mem_in;
  logic [1:0]             r_rd_done;
  logic [1:0]             r_wr_done;

  logic [1:0]             w_pend;
  logic [1:0]             w_ovr;
  logic [1:0]             w_clr;
  logic [1:0]             w_slot_type;
  logic [1:0][ADDR_W-1:0] w_slot_addr;
  logic [1:0][DATA_W-1:0] w_slot_data;
  logic                   w_grant;
  logic                   w_resp;
  logic                   w_timeout;
  logic                   w_done;

  x3q16_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot0 (
    .clk       (clk),
    .reset     (reset),
    .i_req     (m0_request),
    .i_type    (m0_request_type),
    .i_addr    (m0_request_address),
    .i_data    (m0_data_out),
    .i_clr     (w_clr[0]),
    .o_pending (w_pend[0]),
    .o_overrun (w_ovr[0]),
    .o_type    (w_slot_type[0]),
    .o_addr    (w_slot_addr[0]),
    .o_data    (w_slot_data[0])
  );

  x3q16_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot1 (
    .clk       (clk),
    .reset     (reset),
    .i_req     (m1_request),
    .i_type    (m1_request_type),
    .i_addr    (m1_request_address),
    .i_data    (m1_data_out),
    .i_clr     (w_clr[1]),
    .o_pending (w_pend[1]),
    .o_overrun (w_ovr[1]),
    .o_type    (w_slot_type[1]),
    .o_addr    (w_slot_addr[1]),
    .o_data    (w_slot_data[1])
  );

  // Both pending: the port that did not win last time; otherwise the lone one.
  assign w_grant = (w_pend == 2'b11) ? ~r_last_grant : w_pend[1];

  // Only the response matching the in-flight transaction type counts.
  assign w_resp = (r_request_type == REQ_READ) ? memory_ready : write_complete;
  assign w_done = (r_state == WAIT) && (w_resp || w_timeout);

  assign w_clr[0] = w_done && (r_owner == M0);
  assign w_clr[1] = w_done && (r_owner == M1);

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_tmo_cnt;
  logic             r_tmo_err;

  assign w_timeout = (r_state == WAIT) && !w_resp &&
                     (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // WAIT-cycle counter; restarts from zero on every entry to WAIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tmo_cnt <= '0;
      r_tmo_err <= 1'b0;
    end else if ((r_state == WAIT) && !w_resp) begin
      if (w_timeout) begin
        r_tmo_cnt <= '0;
        r_tmo_err <= 1'b1;
      end else begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
    end else begin
      r_tmo_cnt <= '0;
    end
  end

  assign timeout_err = r_tmo_err;
`else
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign w_timeout            = 1'b0;
`endif

  // Arbitration FSM with registered memory-side and requester-side outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state           <= IDLE;
      r_request         <= 1'b0;
      r_request_type    <= REQ_READ;
      r_request_address <= '0;
      r_data_out        <= '0;
      r_owner           <= M0;
      r_last_grant      <= M1;
      r_busy            <= 1'b0;
      r_mem_in          <= '0;
      r_rd_done         <= '0;
      r_wr_done         <= '0;
    end else begin
      r_request <= 1'b0;
      r_rd_done <= '0;
      r_wr_done <= '0;
      case (r_state)
        IDLE: begin
          if (|w_pend) begin
            r_request_type    <= w_slot_type[w_grant];
            r_request_address <= w_slot_addr[w_grant];
            r_data_out        <= w_slot_data[w_grant];
            r_owner           <= w_grant;
            r_last_grant      <= w_grant;
            r_request         <= 1'b1;
            r_busy            <= 1'b1;
            r_state           <= ISSUE;
          end
        end
        ISSUE: begin
          r_state <= WAIT;
        end
        WAIT: begin
          if (w_done) begin
            if (r_request_type == REQ_READ) begin
              r_mem_in[r_owner]  <= w_timeout ? '1 : memory_in;
              r_rd_done[r_owner] <= 1'b1;
            end else begin
              r_wr_done[r_owner] <= 1'b1;
            end
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign request           = r_request;
  assign request_type      = r_request_type;
  assign request_address   = r_request_address;
  assign data_out          = r_data_out;
  assign owner             = r_owner;
  assign busy              = r_busy;
  assign overrun           = w_ovr;
  assign m0_memory_in      = r_mem_in[M0];
  assign m0_memory_ready   = r_rd_done[M0];
  assign m0_write_complete = r_wr_done[M0];
  assign m1_memory_in      = r_mem_in[M1];
  assign m1_memory_ready   = r_rd_done[M1];
  assign m1_write_complete = r_wr_done[M1];

endmodule

// File: tb/tb_x3q16_mem_arbiter.sv
// Scoreboard bench for x3q16_mem_arbiter: stimulus queues the expected memory
// transactions and requester responses; a memory model and a response monitor
// pop and compare independently. Build with +define+ARB_TIMEOUT_EN to add the
// timeout scenario.
module tb_x3q16_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m0_request = 1'b0, m0_request_type = 1'b0;
  logic [15:0] m0_request_address = '0, m0_data_out = '0;
  logic [15:0] m0_memory_in;
  logic        m0_memory_ready, m0_write_complete;
  logic        m1_request = 1'b0, m1_request_type = 1'b0;
  logic [15:0] m1_request_address = '0, m1_data_out = '0;
  logic [15:0] m1_memory_in;
  logic        m1_memory_ready, m1_write_complete;
  logic        request, request_type;
  logic [15:0] request_address, data_out;
  logic [15:0] memory_in = '0;
  logic        memory_ready = 1'b0, write_complete = 1'b0;
  logic        owner, busy;
  logic [1:0]  overrun;
`ifdef ARB_TIMEOUT_EN
  logic        timeout_err;
`endif

  x3q16_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .m0_request(m0_request), .m0_request_type(m0_request_type),
    .m0_request_address(m0_request_address), .m0_data_out(m0_data_out),
    .m0_memory_in(m0_memory_in), .m0_memory_ready(m0_memory_ready),
    .m0_write_complete(m0_write_complete),
    .m1_request(m1_request), .m1_request_type(m1_request_type),
    .m1_request_address(m1_request_address), .m1_data_out(m1_data_out),
    .m1_memory_in(m1_memory_in), .m1_memory_ready(m1_memory_ready),
    .m1_write_complete(m1_write_complete),
    .request(request), .request_type(request_type),
    .request_address(request_address), .data_out(data_out),
    .memory_in(memory_in), .memory_ready(memory_ready),
    .write_complete(write_complete),
    .owner(owner), .busy(busy),
`ifdef ARB_TIMEOUT_EN
    .timeout_err(timeout_err),
`endif
    .overrun(overrun)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic port; logic wr; logic [15:0] addr; logic [15:0] data; } mreq_t;
  typedef struct { int delay; logic silent; logic [15:0] rdata; } mplan_t;
  typedef struct { logic port; logic wr; logic [15:0] data; } rsp_t;

  mreq_t  exp_mreq[$];
  mplan_t mem_plan[$];
  rsp_t   exp_rsp[$];

  int n_checks = 0;
  int n_fail   = 0;
  logic chk_lat = 1'b0;
  int issue_cyc = 0;
  int mem_resp_cyc = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic p, input logic wr, input logic [15:0] a, input logic [15:0] d);
    if (p == 1'b0) begin
      m0_request = 1'b1; m0_request_type = wr; m0_request_address = a; m0_data_out = d;
    end else begin
      m1_request = 1'b1; m1_request_type = wr; m1_request_address = a; m1_data_out = d;
    end
  endtask

  task automatic clr_req(input logic p);
    if (p == 1'b0) m0_request = 1'b0;
    else           m1_request = 1'b0;
  endtask

  task automatic wait_done(input logic p, input int bound);
    int k;
    k = 0;
    while (k < bound) begin
      step();
      k++;
      if (p == 1'b0 && (m0_memory_ready || m0_write_complete)) break;
      if (p == 1'b1 && (m1_memory_ready || m1_write_complete)) break;
    end
    if (k >= bound) fail_now($sformatf("wait_done_timeout port%0d", p));
  endtask

  task automatic drain(input int bound);
    int k;
    k = 0;
    while (exp_rsp.size() != 0 && k < bound) begin
      step();
      k++;
    end
    repeat (6) step();
    if (exp_rsp.size() != 0) begin
      fail_now($sformatf("drain_timeout pending=%0d", exp_rsp.size()));
      exp_rsp.delete();
    end
  endtask

  // Memory model: checks each issued request, then answers per the plan.
  // Writes also see a stray memory_ready one cycle before write_complete.
  mreq_t  mm_e;
  mplan_t mm_p;
  logic   mm_wr;
  always begin
    @(negedge clk);
    if (request) begin
      mm_wr = request_type;
      if (exp_mreq.size() == 0) begin
        fail_now($sformatf("mem_req_unexpected addr=%0h", request_address));
      end else begin
        mm_e = exp_mreq.pop_front();
        chk("mem_req_type", request_type, mm_e.wr);
        chk("mem_req_addr", request_address, mm_e.addr);
        chk("mem_req_owner", owner, mm_e.port);
        chk("mem_busy", busy, 1'b1);
        if (mm_e.wr) chk("mem_req_wdata", data_out, mm_e.data);
      end
      if (chk_lat) chk("mem_req_latency", cyc, issue_cyc + 2);
      if (mem_plan.size() != 0) mm_p = mem_plan.pop_front();
      else mm_p = '{delay: 0, silent: 1'b1, rdata: 16'h0};
      if (!mm_p.silent) begin
        if (mm_wr) begin
          repeat (mm_p.delay - 1) @(posedge clk);
          #1 memory_ready = 1'b1; memory_in = 16'hDEAD;
          @(posedge clk);
          #1 memory_ready = 1'b0; write_complete = 1'b1; mem_resp_cyc = cyc;
          @(posedge clk);
          #1 write_complete = 1'b0;
        end else begin
          repeat (mm_p.delay) @(posedge clk);
          #1 memory_ready = 1'b1; memory_in = mm_p.rdata; mem_resp_cyc = cyc;
          @(posedge clk);
          #1 memory_ready = 1'b0;
        end
      end
    end
  end

  // Response monitor: every requester-side pulse must match the next expected.
  rsp_t        mon_r;
  logic        mon_rd, mon_wr;
  logic [15:0] mon_d;
  always @(negedge clk) begin
    for (int p = 0; p < 2; p++) begin
      mon_rd = (p == 0) ? m0_memory_ready   : m1_memory_ready;
      mon_wr = (p == 0) ? m0_write_complete : m1_write_complete;
      mon_d  = (p == 0) ? m0_memory_in      : m1_memory_in;
      if (mon_rd || mon_wr) begin
        if (exp_rsp.size() == 0) begin
          fail_now($sformatf("rsp_unexpected port%0d rd=%0b wr=%0b", p, mon_rd, mon_wr));
        end else begin
          mon_r = exp_rsp.pop_front();
          chk("rsp_port", p, mon_r.port);
          chk("rsp_kind", {mon_rd, mon_wr}, mon_r.wr ? 2'b01 : 2'b10);
          if (!mon_r.wr) chk("rsp_rdata", mon_d, mon_r.data);
          if (chk_lat) chk("rsp_latency", cyc, mem_resp_cyc + 1);
        end
      end
    end
  end

  task automatic chk_all_zero(input string nm);
    chk({nm, "_m0"}, {m0_memory_in, m0_memory_ready, m0_write_complete}, '0);
    chk({nm, "_m1"}, {m1_memory_in, m1_memory_ready, m1_write_complete}, '0);
    chk({nm, "_memside"}, {request, request_type, request_address, data_out}, '0);
    chk({nm, "_status"}, {owner, busy, overrun}, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) step();
    reset = 1'b0;
    @(negedge clk);
    chk_all_zero("reset_state");
    step();

    // m0 read of 0x0040, memory answers 0xBEEF three cycles after the request
    chk_lat = 1'b1;
    exp_mreq.push_back('{port: 1'b0, wr: 1'b0, addr: 16'h0040, data: 16'h0});
    mem_plan.push_back('{delay: 3, silent: 1'b0, rdata: 16'hBEEF});
    exp_rsp.push_back('{port: 1'b0, wr: 1'b0, data: 16'hBEEF});
    set_req(1'b0, 1'b0, 16'h0040, 16'h0000);
    issue_cyc = cyc;
    step();
    clr_req(1'b0);
    drain(40);
    chk("m0_memory_in_hold", m0_memory_in, 16'hBEEF);
    chk("m1_memory_in_silent", m1_memory_in, 16'h0000);
    chk("idle_not_busy", busy, 1'b0);

    // m1 write of 0x1234 to 0x0100, stray memory_ready during the write
    exp_mreq.push_back('{port: 1'b1, wr: 1'b1, addr: 16'h0100, data: 16'h1234});
    mem_plan.push_back('{delay: 3, silent: 1'b0, rdata: 16'h0});
    exp_rsp.push_back('{port: 1'b1, wr: 1'b1, data: 16'h0});
    set_req(1'b1, 1'b1, 16'h0100, 16'h1234);
    issue_cyc = cyc;
    step();
    clr_req(1'b1);
    drain(40);
    chk("m1_memory_in_after_write", m1_memory_in, 16'h0000);
    chk_lat = 1'b0;

    // Contended back-to-back: both start together, each re-requests on its done
    for (int i = 0; i < 4; i++) begin
      exp_mreq.push_back('{port: 1'b0, wr: 1'b0, addr: 16'h0200 + 16'(i), data: 16'h0});
      mem_plan.push_back('{delay: 2, silent: 1'b0, rdata: 16'hC000 + 16'(i)});
      exp_rsp.push_back('{port: 1'b0, wr: 1'b0, data: 16'hC000 + 16'(i)});
      exp_mreq.push_back('{port: 1'b1, wr: 1'b1, addr: 16'h0300 + 16'(i), data: 16'h5000 + 16'(i)});
      mem_plan.push_back('{delay: 2, silent: 1'b0, rdata: 16'h0});
      exp_rsp.push_back('{port: 1'b1, wr: 1'b1, data: 16'h0});
    end
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          set_req(1'b0, 1'b0, 16'h0200 + 16'(i), 16'h0000);
          step();
          clr_req(1'b0);
          if (i < 3) wait_done(1'b0, 100);
        end
      end
      begin
        for (int j = 0; j < 4; j++) begin
          set_req(1'b1, 1'b1, 16'h0300 + 16'(j), 16'h5000 + 16'(j));
          step();
          clr_req(1'b1);
          if (j < 3) wait_done(1'b1, 100);
        end
      end
    join
    drain(200);
    chk("overrun_after_contention", overrun, 2'b00);

    // Second m0 pulse while the first is pending: dropped, overrun[0] set
    exp_mreq.push_back('{port: 1'b0, wr: 1'b0, addr: 16'h0044, data: 16'h0});
    mem_plan.push_back('{delay: 2, silent: 1'b0, rdata: 16'h1111});
    exp_rsp.push_back('{port: 1'b0, wr: 1'b0, data: 16'h1111});
    set_req(1'b0, 1'b0, 16'h0044, 16'h0000);
    step();
    set_req(1'b0, 1'b0, 16'h0999, 16'h0000);
    step();
    clr_req(1'b0);
    drain(40);
    chk("overrun_m0", overrun, 2'b01);

    // Reset during WAIT: everything clears and the late response is ignored
    exp_mreq.push_back('{port: 1'b1, wr: 1'b0, addr: 16'h0500, data: 16'h0});
    mem_plan.push_back('{delay: 6, silent: 1'b0, rdata: 16'h7777});
    set_req(1'b1, 1'b0, 16'h0500, 16'h0000);
    step();
    clr_req(1'b1);
    step();
    step();
    reset = 1'b1;
    @(negedge clk);
    chk("busy_before_reset_edge", busy, 1'b1);
    step();
    reset = 1'b0;
    @(negedge clk);
    chk_all_zero("reset_mid_wait");
    repeat (10) step();
    chk("no_late_response", {m1_memory_in, m1_memory_ready}, '0);
    chk("idle_after_reset", busy, 1'b0);

`ifdef ARB_TIMEOUT_EN
    // Silent memory on an m0 read: timeout supplies all-ones and flags it
    exp_mreq.push_back('{port: 1'b0, wr: 1'b0, addr: 16'h0600, data: 16'h0});
    mem_plan.push_back('{delay: 0, silent: 1'b1, rdata: 16'h0});
    exp_rsp.push_back('{port: 1'b0, wr: 1'b0, data: 16'hFFFF});
    set_req(1'b0, 1'b0, 16'h0600, 16'h0000);
    step();
    clr_req(1'b0);
    drain(60);
    chk("timeout_err_set", timeout_err, 1'b1);
    exp_mreq.push_back('{port: 1'b1, wr: 1'b0, addr: 16'h0700, data: 16'h0});
    mem_plan.push_back('{delay: 2, silent: 1'b0, rdata: 16'h2468});
    exp_rsp.push_back('{port: 1'b1, wr: 1'b0, data: 16'h2468});
    set_req(1'b1, 1'b0, 16'h0700, 16'h0000);
    step();
    clr_req(1'b1);
    drain(60);
    chk("timeout_err_sticky", timeout_err, 1'b1);
`endif

    repeat (4) step();
    chk("mem_requests_all_seen", exp_mreq.size(), 0);
    chk("responses_all_seen", exp_rsp.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
